userio_ctrl: RTL and testbench

USERIO_CTRL -- requirements
Module: userio_ctrl

---
 rtl/userio_ctrl.sv | 174 +++++++++++++++++
 tb/tb_userio_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/userio_ctrl.sv
// USERIO pad controller: per-pin static, open-drain or pattern drive, plus a
// synchronised input path with sticky rise/fall detection on every pad.
//
// Command semantics: I_start and I_stop are single-cycle pulses sampled on the
// rising edge of usb_clk. Start is accepted only in IDLE; stop is honoured only
// in RUN and wins over a simultaneous start. O_busy is high exactly while the
// engine is in RUN (it is the exposed state); O_done is a one-cycle pulse in
// the first IDLE cycle after a run ends by stop or by pass count.
module userio_ctrl #(
    parameter int pWIDTH     = 8,
    parameter int pDEPTH     = 16,
    parameter int pDIV_WIDTH = 16
) (
    input  logic                       usb_clk,
    input  logic                       reset_n,
    inout  wire  [pWIDTH-1:0]          userio_d,
    input  logic [2*pWIDTH-1:0]        I_mode,
    input  logic [pWIDTH-1:0]          I_drive_data,
    input  logic [pWIDTH*pDEPTH-1:0]   I_pattern,
    input  logic [$clog2(pDEPTH):0]    I_pattern_len,
    input  logic [pDIV_WIDTH-1:0]      I_clkdiv,
    input  logic [7:0]                 I_repeat,
    input  logic                       I_start,
    input  logic                       I_stop,
    input  logic                       I_edge_clear,
    output logic                       O_busy,
    output logic                       O_done,
    output logic [pWIDTH-1:0]          O_userio_sync,
    output logic [pWIDTH-1:0]          O_rise,
    output logic [pWIDTH-1:0]          O_fall
);

    localparam int LW = $clog2(pDEPTH) + 1;
    localparam int IW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         index_q, index_d;
    logic [pDIV_WIDTH-1:0] divcnt_q, divcnt_d;
    logic [pDIV_WIDTH-1:0] clkdiv_q, clkdiv_d;
    logic [7:0]            passcnt_q, passcnt_d;
    logic [7:0]            repeat_q, repeat_d;
    logic [LW-1:0]         len_q, len_d;
    logic                  done_q, done_d;
    logic [7:0]            pass_inc;
    logic [LW-1:0]         len_eff;

    logic [pWIDTH-1:0]     s1, s2, s3;
    logic [pWIDTH-1:0]     rise_q, fall_q;

    // A length of zero or beyond the pattern storage means "use all of it".
    assign len_eff  = (I_pattern_len == '0 || I_pattern_len > LW'(pDEPTH))
                      ? LW'(pDEPTH) : I_pattern_len;
    assign pass_inc = passcnt_q + 8'd1;

    // Engine state register and run parameters latched at start.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            index_q   <= '0;
            divcnt_q  <= '0;
            passcnt_q <= '0;
            clkdiv_q  <= '0;
            repeat_q  <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            divcnt_q  <= divcnt_d;
            passcnt_q <= passcnt_d;
            clkdiv_q  <= clkdiv_d;
            repeat_q  <= repeat_d;
            len_q     <= len_d;
            done_q    <= done_d;
        end
    end

    // Next-state: bit-period divider, pattern index, pass counting, stop/start.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        divcnt_d  = divcnt_q;
        passcnt_d = passcnt_q;
        clkdiv_d  = clkdiv_q;
        repeat_d  = repeat_q;
        len_d     = len_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (I_start && !I_stop) begin
                    state_d   = RUN;
                    index_d   = '0;
                    divcnt_d  = '0;
                    passcnt_d = '0;
                    len_d     = len_eff;
                    clkdiv_d  = I_clkdiv;
                    repeat_d  = I_repeat;
                end
            end
            RUN: begin
                if (I_stop) begin
                    state_d  = IDLE;
                    index_d  = '0;
                    divcnt_d = '0;
                    done_d   = 1'b1;
                end else if (divcnt_q == clkdiv_q) begin
                    divcnt_d = '0;
                    if (LW'(index_q) == len_q - LW'(1)) begin
                        index_d   = '0;
                        passcnt_d = pass_inc;
                        if (repeat_q != 8'd0 && pass_inc == repeat_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        index_d = index_q + IW'(1);
                    end
                end else begin
                    divcnt_d = divcnt_q + pDIV_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pad drivers: purely combinational from mode, static data and the index.
    for (genvar i = 0; i < pWIDTH; i++) begin : g_pad
        logic [1:0]        mode_i;
        logic [pDEPTH-1:0] pat_i;
        logic              pat_bit;
        assign mode_i  = I_mode[2*i +: 2];
        assign pat_i   = I_pattern[i*pDEPTH +: pDEPTH];
        assign pat_bit = pat_i[index_q];
        assign userio_d[i] = (mode_i == 2'd1) ? I_drive_data[i] :
                             (mode_i == 2'd2) ? pat_bit :
                             (mode_i == 2'd3 && !I_drive_data[i]) ? 1'b0 : 1'bz;
`ifndef __ICARUS__
        pullup pu_pad (userio_d[i]);
`endif
    end

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '1;
            s2 <= '1;
            s3 <= '1;
        end else begin
            s1 <= userio_d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Sticky edge flags; a new edge wins over a simultaneous clear.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= (rise_q & ~{pWIDTH{I_edge_clear}}) | (s2 & ~s3);
            fall_q <= (fall_q & ~{pWIDTH{I_edge_clear}}) | (~s2 & s3);
        end
    end

    assign O_busy        = (state_q == RUN);
    assign O_done        = done_q;
    assign O_userio_sync = s2;
    assign O_rise        = rise_q;
    assign O_fall        = fall_q;

endmodule

// File: tb/tb_userio_ctrl.sv
// Self-checking bench for userio_ctrl: directed scenarios plus a randomised
// phase, all checked against a timeline model of the pattern engine and pads.
module tb_userio_ctrl;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int DW = 16;
    localparam int LW = $clog2(D) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    wire  [W-1:0]      pad;
    logic [W-1:0]      tb_oe, tb_val;
    logic [2*W-1:0]    mode;
    logic [W-1:0]      drv;
    logic [W*D-1:0]    pattern;
    logic [LW-1:0]     plen;
    logic [DW-1:0]     clkdiv;
    logic [7:0]        rep;
    logic              start, stop, eclr;
    logic              busy, done;
    logic [W-1:0]      sync, rise, fall;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic              m_busy, m_done;
    int                m_n, m_L, m_D, m_R;
    logic [W-1:0]      m_rise, m_fall;
    logic [W-1:0]      hist[$];
    logic [W-1:0]      exp_q[$];

    userio_ctrl #(.pWIDTH(W), .pDEPTH(D), .pDIV_WIDTH(DW)) dut (
        .usb_clk(clk), .reset_n(rst_n), .userio_d(pad),
        .I_mode(mode), .I_drive_data(drv), .I_pattern(pattern),
        .I_pattern_len(plen), .I_clkdiv(clkdiv), .I_repeat(rep),
        .I_start(start), .I_stop(stop), .I_edge_clear(eclr),
        .O_busy(busy), .O_done(done), .O_userio_sync(sync),
        .O_rise(rise), .O_fall(fall)
    );

    // board side: optional external driver and pullup per pad
    for (genvar i = 0; i < W; i++) begin : g_board
        assign pad[i] = tb_oe[i] ? tb_val[i] : 1'bz;
        pullup pu_board (pad[i]);
    end

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int eff_len(input logic [LW-1:0] l);
        return (l == 0 || int'(l) > D) ? D : int'(l);
    endfunction

    // Expected pad level: the bit index follows from elapsed run cycles.
    function automatic logic [W-1:0] model_pad();
        logic [W-1:0] p;
        int idx;
        idx = m_busy ? (m_n / (m_D + 1)) % m_L : 0;
        for (int i = 0; i < W; i++) begin
            case (mode[2*i +: 2])
                2'd0: p[i] = tb_oe[i] ? tb_val[i] : 1'b1;
                2'd1: p[i] = drv[i];
                2'd2: p[i] = pattern[i*D + idx];
                default: p[i] = !drv[i] ? 1'b0 : (tb_oe[i] ? tb_val[i] : 1'b1);
            endcase
        end
        return p;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_done = 1'b0; m_n = 0;
        m_L = D; m_D = 0; m_R = 0;
        m_rise = '0; m_fall = '0;
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_back('1);
    endtask

    // Advance the model across one rising edge, using this cycle's inputs.
    task automatic model_edge(input logic [W-1:0] p);
        logic [W-1:0] ev_r, ev_f;
        m_done = 1'b0;
        if (m_busy) begin
            if (stop) begin
                m_busy = 1'b0; m_done = 1'b1; m_n = 0;
            end else begin
                m_n++;
                if (m_R != 0 && m_n == m_R * (m_D + 1) * m_L) begin
                    m_busy = 1'b0; m_done = 1'b1; m_n = 0;
                end
            end
        end else if (start && !stop) begin
            m_busy = 1'b1; m_n = 0;
            m_L = eff_len(plen); m_D = int'(clkdiv); m_R = int'(rep);
        end
        hist.push_back(p);
        if (hist.size() > 8) void'(hist.pop_front());
        // pad seen two edges ago vs three edges ago
        ev_r = hist[hist.size()-3] & ~hist[hist.size()-4];
        ev_f = ~hist[hist.size()-3] & hist[hist.size()-4];
        m_rise = (m_rise & ~{W{eclr}}) | ev_r;
        m_fall = (m_fall & ~{W{eclr}}) | ev_f;
    endtask

    // One clock cycle: check outputs, take the edge, clear command pulses.
    task automatic step();
        logic [W-1:0] ep;
        #1;
        ep = model_pad();
        check("pad", pad, ep);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("sync", sync, hist[hist.size()-2]);
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
        @(posedge clk);
        model_edge(ep);
        @(negedge clk);
        start = 1'b0; stop = 1'b0; eclr = 1'b0;
    endtask

    task automatic reset_mid_cycle();
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sync", sync, {W{1'b1}});
        check("rst_rise", rise, '0);
        check("rst_fall", fall, '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_pattern();
        for (int k = 0; k < W*D/32; k++) pattern[32*k +: 32] = $urandom();
    endtask

    initial begin
        int busy_cnt, done_cnt;
        rst_n = 1'b0;
        tb_oe = '0; tb_val = '0; mode = '0; drv = '0; pattern = '0;
        plen = '0; clkdiv = '0; rep = '0; start = 1'b0; stop = 1'b0; eclr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("por_busy", busy, 1'b0);
        check("por_sync", sync, {W{1'b1}});
        check("por_rise", rise, '0);
        rst_n = 1'b1;
        repeat (3) step();

        // A5A5 on pin 0, two cycles per bit, one pass
        mode = 16'h0002; rand_pattern(); pattern[0 +: D] = 16'hA5A5;
        plen = LW'(16); clkdiv = 16'd1; rep = 8'd1;
        for (int n = 0; n < 32; n++) exp_q.push_back({{(W-1){1'b1}}, 1'((16'hA5A5 >> (n/2)) & 1)});
        start = 1'b1; step();
        busy_cnt = 0; done_cnt = 0;
        for (int n = 0; n < 32; n++) begin
            #1;
            check("a5_seq", pad, exp_q.pop_front());
            busy_cnt += int'(busy); done_cnt += int'(done);
            step();
        end
        for (int n = 0; n < 4; n++) begin
            busy_cnt += int'(busy); done_cnt += int'(done);
            step();
        end
        check("a5_busy_cycles", busy_cnt, 32);
        check("a5_done_pulses", done_cnt, 1);

        // endless short loop stopped after ten cycles
        rand_pattern(); plen = LW'(4); clkdiv = '0; rep = '0;
        start = 1'b1; step();
        repeat (10) step();
        stop = 1'b1; step();
        done_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            done_cnt += int'(done);
            check("after_stop_busy", busy, 1'b0);
            step();
        end
        check("stop_done_pulses", done_cnt, 1);

        // start and stop together from IDLE; start while running
        start = 1'b1; stop = 1'b1; step();
        check("startstop_idle", busy, 1'b0);
        plen = LW'(8); clkdiv = 16'd2; rep = 8'd0; mode = 16'h5556;
        start = 1'b1; step();
        repeat (5) step();
        start = 1'b1; step();
        repeat (6) step();
        stop = 1'b1; step();
        repeat (2) step();

        // open-drain pin 3 released high, board pulls it low
        mode = '0; mode[7:6] = 2'd3; drv = 8'h08;
        tb_oe = 8'h08; tb_val = 8'h00;
        repeat (4) step();
        check("od_sync3", sync[3], 1'b0);
        check("od_fall3", fall[3], 1'b1);
        check("od_rise3", rise[3], 1'b0);

        // release: clear coinciding with the rise edge keeps the flag
        tb_oe = '0; step(); step();
        eclr = 1'b1; step();
        check("clr_edge_rise3", rise[3], 1'b1);
        check("clr_edge_fall3", fall[3], 1'b0);
        step();
        eclr = 1'b1; step();
        check("clr_quiet_rise3", rise[3], 1'b0);

        // randomised phase
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                mode = 16'($urandom()); drv = 8'($urandom()); rand_pattern();
                plen = LW'($urandom_range(0, 31)); clkdiv = DW'($urandom_range(0, 3));
                rep = 8'($urandom_range(0, 3));
            end
            tb_oe = '0;
            for (int i = 0; i < W; i++)
                if (mode[2*i +: 2] == 2'd0 || (mode[2*i +: 2] == 2'd3 && drv[i]))
                    tb_oe[i] = 1'($urandom_range(0, 1));
            tb_val = 8'($urandom());
            if ($urandom_range(0, 7) == 0) pattern[0 +: 32] = $urandom();
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            eclr  = ($urandom_range(0, 11) == 0);
            if (c == 200) reset_mid_cycle();
            step();
        end

        // reset in the middle of a run, quiet pads afterwards
        mode = 16'h0002; tb_oe = '0; rand_pattern(); plen = LW'(5); clkdiv = 16'd1; rep = '0;
        start = 1'b1; step();
        repeat (4) step();
        mode = '0;
        reset_mid_cycle();
        repeat (6) step();
        check("post_rst_rise", rise, '0);
        check("post_rst_fall", fall, '0);
        check("post_rst_sync", sync, {W{1'b1}});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
